id_regfile_hazard: RTL and testbench

Decode-stage block feeding the D/E pipeline register of the 5-stage RISC core. It holds the 32x32 architectural register file with write-through bypass from writeback, detects load-use hazards and branch redirects, and drives the F/D stall and flush plus the D/E flush (DEFlush). It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/id_regfile_hazard_pkg.sv | 9 +
 rtl/id_regfile_hazard_regfile.sv | 41 ++++
 rtl/id_regfile_hazard.sv | 87 ++++++++
 tb/tb_id_regfile_hazard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_hazard_pkg.sv
// Shared decode-stage constants: register index width, the x0 index and
// the active-low write-enable level used by the D/E register as well.
package id_regfile_hazard_pkg;

    localparam int               REG_IDX_W  = 5;
    localparam logic [REG_IDX_W-1:0] X0     = '0;
    localparam logic             WEN_ACTIVE = 1'b0;

endpackage

// File: rtl/id_regfile_hazard_regfile.sv
// 2-read/1-write architectural register array with async clear, hardwired
// x0 and same-cycle write-through bypass from writeback.
module regfile_2r1w
    import id_regfile_hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_IDX_W-1:0] ra0,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic                 wen,
    input  logic [DW-1:0]        wd,
    output logic [DW-1:0]        dout0,
    output logic [DW-1:0]        dout1
);

    logic [DW-1:0] regs [NREG];
    logic          wr_ok;

    assign wr_ok = (wen == WEN_ACTIVE) && (wa != X0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // Writes to x0 never bypass, so x0 reads are forced to zero first.
    assign dout0 = (ra0 == X0)               ? '0 :
                   (wr_ok && (wa == ra0))    ? wd : regs[ra0];
    assign dout1 = (ra1 == X0)               ? '0 :
                   (wr_ok && (wa == ra1))    ? wd : regs[ra1];

endmodule

// File: rtl/id_regfile_hazard.sv
// Decode stage: register file, load-use / redirect hazard control for the
// F/D and D/E registers, and saturating stall/flush event counters.
module id_regfile_hazard
    import id_regfile_hazard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [REG_IDX_W-1:0] RA0_D,
    input  logic [REG_IDX_W-1:0] RA1_D,
    input  logic                 RS1Used_D,
    input  logic                 RS2Used_D,
    input  logic [REG_IDX_W-1:0] WA_E,
    input  logic                 WEN_E,
    input  logic                 Load_E,
    input  logic                 JTaken_E,
    input  logic [REG_IDX_W-1:0] WA_W,
    input  logic                 WEN_W,
    input  logic [DW-1:0]        WD_W,
    input  logic                 CntClr,
    output logic [DW-1:0]        DOUT0_D,
    output logic [DW-1:0]        DOUT1_D,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FDFlush,
    output logic                 DEFlush,
    output logic [CNT_W-1:0]     StallCnt,
    output logic [CNT_W-1:0]     FlushCnt
);

    logic lu;

    regfile_2r1w #(
        .NREG (NREG),
        .DW   (DW)
    ) u_rf (
        .clk   (CLK),
        .rstn  (RSTN),
        .ra0   (RA0_D),
        .ra1   (RA1_D),
        .wa    (WA_W),
        .wen   (WEN_W),
        .wd    (WD_W),
        .dout0 (DOUT0_D),
        .dout1 (DOUT1_D)
    );

    assign lu = Load_E && (WEN_E == WEN_ACTIVE) && (WA_E != X0) &&
                ((RS1Used_D && (RA0_D == WA_E)) || (RS2Used_D && (RA1_D == WA_E)));

    // A taken redirect squashes the D instruction, so it overrides a stall.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        FDFlush = 1'b0;
        DEFlush = 1'b0;
        if (JTaken_E) begin
            FDFlush = 1'b1;
            DEFlush = 1'b1;
        end else if (lu) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            DEFlush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (CntClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (lu && !JTaken_E && (StallCnt != '1)) begin
                StallCnt <= StallCnt + 1'b1;
            end
            if (JTaken_E && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_regfile_hazard.sv
// Directed bench: hazard truth table vectors plus hand-written sequences for
// bypass, x0, counters, saturation and asynchronous reset.
module tb_id_regfile_hazard;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [4:0]  RA0_D, RA1_D, WA_E, WA_W;
    logic        RS1Used_D, RS2Used_D, WEN_E, Load_E, JTaken_E, WEN_W, CntClr;
    logic [31:0] WD_W;
    logic [31:0] DOUT0_D, DOUT1_D, s_dout0, s_dout1;
    logic        StallF, StallD, FDFlush, DEFlush;
    logic        s_stallf, s_stalld, s_fdflush, s_deflush;
    logic [15:0] StallCnt, FlushCnt;
    logic [3:0]  s_stallcnt, s_flushcnt;

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    id_regfile_hazard dut (
        .CLK(CLK), .RSTN(RSTN), .RA0_D(RA0_D), .RA1_D(RA1_D),
        .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D), .WA_E(WA_E), .WEN_E(WEN_E),
        .Load_E(Load_E), .JTaken_E(JTaken_E), .WA_W(WA_W), .WEN_W(WEN_W), .WD_W(WD_W),
        .CntClr(CntClr), .DOUT0_D(DOUT0_D), .DOUT1_D(DOUT1_D), .StallF(StallF),
        .StallD(StallD), .FDFlush(FDFlush), .DEFlush(DEFlush),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    // Narrow-counter instance used only for the saturation check.
    id_regfile_hazard #(.CNT_W(4)) dut_small (
        .CLK(CLK), .RSTN(RSTN), .RA0_D(RA0_D), .RA1_D(RA1_D),
        .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D), .WA_E(WA_E), .WEN_E(WEN_E),
        .Load_E(Load_E), .JTaken_E(JTaken_E), .WA_W(WA_W), .WEN_W(WEN_W), .WD_W(WD_W),
        .CntClr(CntClr), .DOUT0_D(s_dout0), .DOUT1_D(s_dout1), .StallF(s_stallf),
        .StallD(s_stalld), .FDFlush(s_fdflush), .DEFlush(s_deflush),
        .StallCnt(s_stallcnt), .FlushCnt(s_flushcnt)
    );

    typedef struct {
        logic [4:0] ra0, ra1, wa_e;
        logic       rs1u, rs2u, wen_e, load_e, jt;
        logic [3:0] exp; // {StallF, StallD, FDFlush, DEFlush}
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RA0_D     = v.ra0;
        RA1_D     = v.ra1;
        WA_E      = v.wa_e;
        RS1Used_D = v.rs1u;
        RS2Used_D = v.rs2u;
        WEN_E     = v.wen_e;
        Load_E    = v.load_e;
        JTaken_E  = v.jt;
    endtask

    task automatic setLoadUse();
        Load_E = 1'b1; WEN_E = 1'b0; WA_E = 5'd7;
        RS2Used_D = 1'b1; RA1_D = 5'd7; RS1Used_D = 1'b0; RA0_D = 5'd1;
    endtask

    task automatic clearCounters();
        @(negedge CLK);
        CntClr = 1'b1;
        @(negedge CLK);
        CntClr = 1'b0;
    endtask

    initial begin
        //            ra0    ra1    wa_e   rs1u  rs2u  wen_e load  jt    exp
        vecs[0] = '{5'd1,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[1] = '{5'd1,  5'd7,  5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[2] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[3] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[4] = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[5] = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[6] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011};
        vecs[7] = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[8] = '{5'd12, 5'd3,  5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101};

        RSTN = 1'b0; CntClr = 1'b0;
        RA0_D = 5'd5; RA1_D = 5'd5; RS1Used_D = 1'b0; RS2Used_D = 1'b0;
        WA_E = 5'd0; WEN_E = 1'b1; Load_E = 1'b0; JTaken_E = 1'b0;
        WA_W = 5'd0; WEN_W = 1'b1; WD_W = 32'h0;
        #1;
        checkOutput("reset_dout0", DOUT0_D, 32'h0);
        checkOutput("reset_stallcnt", {16'h0, StallCnt}, 32'h0);
        checkOutput("reset_flushcnt", {16'h0, FlushCnt}, 32'h0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Write-through then array read
        @(negedge CLK);
        WEN_W = 1'b0; WA_W = 5'd5; WD_W = 32'hDEADBEEF; RA0_D = 5'd5;
        #1 checkOutput("bypass_same_cycle", DOUT0_D, 32'hDEADBEEF);
        @(negedge CLK);
        WEN_W = 1'b1;
        #1 checkOutput("array_next_cycle", DOUT0_D, 32'hDEADBEEF);

        // x0 rule: no write, no bypass
        @(negedge CLK);
        WEN_W = 1'b0; WA_W = 5'd0; WD_W = 32'h1234; RA0_D = 5'd0; RA1_D = 5'd5;
        #1 checkOutput("x0_same_cycle", DOUT0_D, 32'h0);
        checkOutput("x0_no_bypass_port1", DOUT1_D, 32'hDEADBEEF);
        @(negedge CLK);
        WEN_W = 1'b1;
        #1 checkOutput("x0_next_cycle", DOUT0_D, 32'h0);

        // Both ports bypass the same writeback
        @(negedge CLK);
        WEN_W = 1'b0; WA_W = 5'd9; WD_W = 32'h55AA33CC; RA0_D = 5'd9; RA1_D = 5'd9;
        #1 checkOutput("dual_bypass_p0", DOUT0_D, 32'h55AA33CC);
        checkOutput("dual_bypass_p1", DOUT1_D, 32'h55AA33CC);
        @(negedge CLK);
        WEN_W = 1'b1;

        // Hazard truth table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            #1 checkOutput($sformatf("vec%0d_ctrl", i),
                           {28'h0, StallF, StallD, FDFlush, DEFlush}, {28'h0, vecs[i].exp});
            @(negedge CLK);
        end
        Load_E = 1'b0; JTaken_E = 1'b0;

        // Load-use: one stall, counted once
        clearCounters();
        checkOutput("lu_cnt_cleared", {16'h0, StallCnt}, 32'h0);
        setLoadUse();
        #1 checkOutput("lu_ctrl", {28'h0, StallF, StallD, FDFlush, DEFlush}, 32'hD);
        @(negedge CLK);
        checkOutput("lu_stallcnt_1", {16'h0, StallCnt}, 32'd1);
        Load_E = 1'b0;
        #1 checkOutput("lu_released", {28'h0, StallF, StallD, FDFlush, DEFlush}, 32'h0);
        @(negedge CLK);
        checkOutput("lu_stallcnt_hold", {16'h0, StallCnt}, 32'd1);

        // Redirect during load-use
        setLoadUse();
        JTaken_E = 1'b1;
        #1 checkOutput("redir_ctrl", {28'h0, StallF, StallD, FDFlush, DEFlush}, 32'h3);
        @(negedge CLK);
        checkOutput("redir_flushcnt", {16'h0, FlushCnt}, 32'd1);
        checkOutput("redir_stallcnt", {16'h0, StallCnt}, 32'd1);
        JTaken_E = 1'b0; Load_E = 1'b0;

        // Saturation and clear
        clearCounters();
        setLoadUse();
        repeat (20) @(negedge CLK);
        checkOutput("sat_small_stallcnt", {28'h0, s_stallcnt}, 32'd15);
        checkOutput("sat_big_stallcnt", {16'h0, StallCnt}, 32'd20);
        CntClr = 1'b1;
        @(negedge CLK);
        CntClr = 1'b0;
        checkOutput("clr_small_stallcnt", {28'h0, s_stallcnt}, 32'd0);
        checkOutput("clr_big_stallcnt", {16'h0, StallCnt}, 32'd0);

        // Async reset mid-stall between clock edges
        WEN_W = 1'b0; WA_W = 5'd3; WD_W = 32'hA5A5A5A5;
        @(negedge CLK);
        WEN_W = 1'b1; RA0_D = 5'd3; JTaken_E = 1'b1;
        #1 checkOutput("reg3_written", DOUT0_D, 32'hA5A5A5A5);
        @(negedge CLK);
        JTaken_E = 1'b0;
        #2 RSTN = 1'b0;
        #1;
        checkOutput("arst_dout0", DOUT0_D, 32'h0);
        checkOutput("arst_stallcnt", {16'h0, StallCnt}, 32'h0);
        checkOutput("arst_flushcnt", {16'h0, FlushCnt}, 32'h0);
        checkOutput("arst_ctrl", {28'h0, StallF, StallD, FDFlush, DEFlush}, 32'hD);
        #1 RSTN = 1'b1;
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
